// File: rtl/life_cell_board.sv
// Conway's Game of Life board: cells are edited while idle, and each change_state
// rising edge computes one generation on a torus, one cell per clock.
module life_cell_board #(
    parameter int MAP_WIDTH  = 8,
    parameter int MAP_HEIGHT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        change_state,
    input  logic        write_en,
    input  logic        write_data,
    input  logic [7:0]  wAddrR,
    input  logic [7:0]  wAddrC,
    input  logic [7:0]  rAddrR,
    input  logic [7:0]  rAddrC,
    output logic        rData,
    output logic        busy,
    output logic [15:0] gen_count,
    output logic [15:0] alive_count
);

    localparam int CELLS = MAP_WIDTH * MAP_HEIGHT;
    localparam int RW    = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1;
    localparam int CW    = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
    localparam int IDXW  = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(MAP_HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_LAST = CW'(MAP_WIDTH - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             cs_r;
    logic [RW-1:0]    r_r;
    logic [CW-1:0]    c_r;
    logic [15:0]      pop_r;
    logic [CELLS-1:0] cur_r;
    logic [CELLS-1:0] nxt_r;
    logic             rdata_r;
    logic             busy_r;
    logic [15:0]      gen_r;
    logic [15:0]      alive_r;

    logic             edge_s;
    logic             last_col_s;
    logic             last_row_s;
    logic [RW-1:0]    row_up_s;
    logic [RW-1:0]    row_dn_s;
    logic [CW-1:0]    col_lt_s;
    logic [CW-1:0]    col_rt_s;
    logic [3:0]       nbr_s;
    logic             next_cell_s;
    logic             wr_in_range_s;
    logic             wr_ok_s;
    logic [IDXW-1:0]  wr_idx_s;
    logic             rd_in_range_s;
    logic [IDXW-1:0]  rd_idx_s;

    function automatic logic [IDXW-1:0] cell_idx(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col);
        return IDXW'(int'(row) * MAP_WIDTH + int'(col));
    endfunction

    assign edge_s     = change_state & ~cs_r;
    assign last_col_s = (c_r == COL_LAST);
    assign last_row_s = (r_r == ROW_LAST);

    // Toroidal neighbour coordinates of the cell under evaluation.
    assign row_up_s = (r_r == {RW{1'b0}}) ? ROW_LAST : (r_r - ROW_ONE);
    assign row_dn_s = last_row_s ? {RW{1'b0}} : (r_r + ROW_ONE);
    assign col_lt_s = (c_r == {CW{1'b0}}) ? COL_LAST : (c_r - COL_ONE);
    assign col_rt_s = last_col_s ? {CW{1'b0}} : (c_r + COL_ONE);

    assign nbr_s = {3'b000, cur_r[cell_idx(row_up_s, col_lt_s)]}
                 + {3'b000, cur_r[cell_idx(row_up_s, c_r)]}
                 + {3'b000, cur_r[cell_idx(row_up_s, col_rt_s)]}
                 + {3'b000, cur_r[cell_idx(r_r, col_lt_s)]}
                 + {3'b000, cur_r[cell_idx(r_r, col_rt_s)]}
                 + {3'b000, cur_r[cell_idx(row_dn_s, col_lt_s)]}
                 + {3'b000, cur_r[cell_idx(row_dn_s, c_r)]}
                 + {3'b000, cur_r[cell_idx(row_dn_s, col_rt_s)]};

    assign next_cell_s = (nbr_s == 4'd3) | (cur_r[cell_idx(r_r, c_r)] & (nbr_s == 4'd2));

    // Out-of-range addresses are masked so they never alias onto a real cell.
    assign wr_in_range_s = (int'(wAddrR) < MAP_HEIGHT) && (int'(wAddrC) < MAP_WIDTH);
    assign wr_idx_s      = wr_in_range_s ? cell_idx(RW'(wAddrR), CW'(wAddrC)) : {IDXW{1'b0}};
    assign wr_ok_s       = write_en & ~mode & (state_r == ST_IDLE) & wr_in_range_s;
    assign rd_in_range_s = (int'(rAddrR) < MAP_HEIGHT) && (int'(rAddrC) < MAP_WIDTH);
    assign rd_idx_s      = rd_in_range_s ? cell_idx(RW'(rAddrR), CW'(rAddrC)) : {IDXW{1'b0}};

    // Next-state decode; dropping mode mid-scan aborts without committing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (edge_s & mode) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (!mode) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_row_s & last_col_s) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer: state, edge detect, scan indices, population and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cs_r    <= 1'b0;
            r_r     <= {RW{1'b0}};
            c_r     <= {CW{1'b0}};
            pop_r   <= 16'd0;
            gen_r   <= 16'd0;
            alive_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            cs_r    <= change_state;
            case (state_r)
                ST_IDLE: begin
                    if (edge_s & mode) begin
                        r_r   <= {RW{1'b0}};
                        c_r   <= {CW{1'b0}};
                        pop_r <= 16'd0;
                    end
                end
                ST_COMPUTE: begin
                    if (next_cell_s) begin
                        pop_r <= pop_r + 16'd1;
                    end
                    if (last_col_s) begin
                        c_r <= {CW{1'b0}};
                        r_r <= last_row_s ? {RW{1'b0}} : (r_r + ROW_ONE);
                    end else begin
                        c_r <= c_r + COL_ONE;
                    end
                end
                ST_COMMIT: begin
                    gen_r   <= gen_r + 16'd1;
                    alive_r <= pop_r;
                end
                default: begin
                    gen_r <= gen_r;
                end
            endcase
        end
    end

    // Board banks: edits and commits update cur; the scan only fills nxt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_r <= {CELLS{1'b0}};
            nxt_r <= {CELLS{1'b0}};
        end else begin
            if (state_r == ST_COMMIT) begin
                cur_r <= nxt_r;
            end else if (wr_ok_s) begin
                cur_r[wr_idx_s] <= write_data;
            end
            if (state_r == ST_COMPUTE) begin
                nxt_r[cell_idx(r_r, c_r)] <= next_cell_s;
            end
        end
    end

    // Display read port, one clock of latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= 1'b0;
        end else begin
            rdata_r <= rd_in_range_s ? cur_r[rd_idx_s] : 1'b0;
        end
    end

    assign rData       = rdata_r;
    assign busy        = busy_r;
    assign gen_count   = gen_r;
    assign alive_count = alive_r;

endmodule

// File: tb/tb_life_cell_board.sv
// Self-checking bench for life_cell_board: random and directed boards are checked
// against a plain array model of the Game of Life rules on a torus.
module tb_life_cell_board;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        change_state = 1'b0;
    logic        write_en = 1'b0;
    logic        write_data = 1'b0;
    logic [7:0]  wAddrR = 8'd0;
    logic [7:0]  wAddrC = 8'd0;
    logic [7:0]  rAddrR = 8'd0;
    logic [7:0]  rAddrC = 8'd0;
    logic        rData;
    logic        busy;
    logic [15:0] gen_count;
    logic [15:0] alive_count;

    int checks = 0;
    int failures = 0;

    bit model [0:H-1][0:W-1];
    int gen_m = 0;
    int alive_m = 0;

    always #5 clk = ~clk;

    life_cell_board #(.MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .mode(mode), .change_state(change_state),
        .write_en(write_en), .write_data(write_data),
        .wAddrR(wAddrR), .wAddrC(wAddrC), .rAddrR(rAddrR), .rAddrC(rAddrC),
        .rData(rData), .busy(busy), .gen_count(gen_count), .alive_count(alive_count)
    );

    function automatic logic [W*H-1:0] model_vec();
        logic [W*H-1:0] v;
        v = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                v[r*W+c] = model[r][c];
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                model[r][c] = 1'b0;
        gen_m = 0;
        alive_m = 0;
    endtask

    task automatic step_model();
        bit nb [0:H-1][0:W-1];
        int n;
        alive_m = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(model[(r + dr + H) % H][(c + dc + W) % W]);
                nb[r][c] = (n == 3) || (model[r][c] && n == 2);
                alive_m += int'(nb[r][c]);
            end
        end
        model = nb;
        gen_m = (gen_m + 1) % 65536;
    endtask

    task automatic do_write(input int r, input int c, input bit d);
        mode = 1'b0;
        write_en = 1'b1;
        wAddrR = 8'(r);
        wAddrC = 8'(c);
        write_data = d;
        @(posedge clk); #1;
        write_en = 1'b0;
        model[r][c] = d;
    endtask

    task automatic clear_board();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                do_write(r, c, 1'b0);
    endtask

    task automatic read_board(output logic [W*H-1:0] v);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                rAddrR = 8'(r);
                rAddrC = 8'(c);
                @(posedge clk); #1;
                v[r*W+c] = rData;
            end
        end
    endtask

    task automatic run_gen(output int cycles);
        mode = 1'b1;
        change_state = 1'b1;
        @(posedge clk); #1;
        change_state = 1'b0;
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [W*H-1:0] got;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rData !== 1'b0) begin failures++; $display("FAIL reset_rdata got=%b exp=0", rData); end
        checks++; if (gen_count !== 16'd0) begin failures++; $display("FAIL reset_gen got=%0d exp=0", gen_count); end
        checks++; if (alive_count !== 16'd0) begin failures++; $display("FAIL reset_alive got=%0d exp=0", alive_count); end
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        read_board(got);
        checks++; if (got !== model_vec()) begin failures++; $display("FAIL reset_board got=%h exp=%h", got, model_vec()); end
    endtask

    task automatic test_blinker();
        logic [W*H-1:0] got;
        int cyc;
        do_write(3, 2, 1'b1);
        do_write(3, 3, 1'b1);
        do_write(3, 4, 1'b1);
        for (int g = 0; g < 2; g++) begin
            run_gen(cyc);
            step_model();
            checks++; if (cyc !== 65) begin failures++; $display("FAIL blinker_latency gen%0d got=%0d exp=65", g, cyc); end
            read_board(got);
            checks++; if (got !== model_vec()) begin failures++; $display("FAIL blinker_board gen%0d got=%h exp=%h", g, got, model_vec()); end
            checks++; if (gen_count !== 16'(gen_m)) begin failures++; $display("FAIL blinker_gen got=%0d exp=%0d", gen_count, gen_m); end
            checks++; if (alive_count !== 16'(alive_m)) begin failures++; $display("FAIL blinker_alive got=%0d exp=%0d", alive_count, alive_m); end
        end
    endtask

    task automatic test_wrap();
        logic [W*H-1:0] got;
        int cyc;
        clear_board();
        do_write(0, 7, 1'b1);
        do_write(7, 7, 1'b1);
        do_write(1, 7, 1'b1);
        run_gen(cyc);
        step_model();
        read_board(got);
        checks++; if (got !== model_vec()) begin failures++; $display("FAIL wrap_board got=%h exp=%h", got, model_vec()); end
        checks++; if (alive_count !== 16'd3) begin failures++; $display("FAIL wrap_alive got=%0d exp=3", alive_count); end
        checks++; if (gen_count !== 16'(gen_m)) begin failures++; $display("FAIL wrap_gen got=%0d exp=%0d", gen_count, gen_m); end
    endtask

    task automatic test_random();
        logic [W*H-1:0] got;
        int cyc;
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    do_write(r, c, ($urandom_range(0, 2) == 0));
            for (int g = 0; g < 2; g++) begin
                run_gen(cyc);
                step_model();
                read_board(got);
                checks++; if (got !== model_vec()) begin failures++; $display("FAIL random_board t%0d g%0d got=%h exp=%h", t, g, got, model_vec()); end
                checks++; if (alive_count !== 16'(alive_m)) begin failures++; $display("FAIL random_alive t%0d got=%0d exp=%0d", t, alive_count, alive_m); end
                checks++; if (gen_count !== 16'(gen_m)) begin failures++; $display("FAIL random_gen t%0d got=%0d exp=%0d", t, gen_count, gen_m); end
                checks++; if (cyc !== 65) begin failures++; $display("FAIL random_latency t%0d got=%0d exp=65", t, cyc); end
            end
        end
    endtask

    task automatic test_ignored_writes();
        logic [W*H-1:0] got;
        do_write(0, 0, 1'b0);
        do_write(1, 0, 1'b0);
        mode = 1'b1;
        write_en = 1'b1; wAddrR = 8'd0; wAddrC = 8'd0; write_data = 1'b1;
        @(posedge clk); #1;
        mode = 1'b0;
        wAddrR = 8'd0; wAddrC = 8'd8;
        @(posedge clk); #1;
        wAddrR = 8'd8; wAddrC = 8'd0;
        @(posedge clk); #1;
        wAddrR = 8'd200; wAddrC = 8'd3;
        @(posedge clk); #1;
        write_en = 1'b0;
        read_board(got);
        checks++; if (got !== model_vec()) begin failures++; $display("FAIL ignored_board got=%h exp=%h", got, model_vec()); end
        checks++; if (gen_count !== 16'(gen_m)) begin failures++; $display("FAIL edit_gen got=%0d exp=%0d", gen_count, gen_m); end
        checks++; if (alive_count !== 16'(alive_m)) begin failures++; $display("FAIL edit_alive got=%0d exp=%0d", alive_count, alive_m); end
        do_write(0, 0, 1'b1);
        do_write(1, 0, 1'b1);
        rAddrR = 8'd0; rAddrC = 8'd8;
        @(posedge clk); #1;
        checks++; if (rData !== 1'b0) begin failures++; $display("FAIL oor_read_col got=%b exp=0", rData); end
        rAddrR = 8'd8; rAddrC = 8'd0;
        @(posedge clk); #1;
        checks++; if (rData !== 1'b0) begin failures++; $display("FAIL oor_read_row got=%b exp=0", rData); end
    endtask

    task automatic test_dropped_edge();
        logic [W*H-1:0] got;
        int busy_cnt;
        int first_low;
        busy_cnt = 0;
        first_low = 0;
        mode = 1'b1;
        change_state = 1'b1;
        for (int n = 1; n <= 130; n++) begin
            @(posedge clk); #1;
            if (n == 1) change_state = 1'b0;
            if (n == 10) change_state = 1'b1;
            if (n == 11) change_state = 1'b0;
            if (busy) busy_cnt++;
            else if (first_low == 0) first_low = n;
        end
        step_model();
        checks++; if (busy_cnt !== 65) begin failures++; $display("FAIL dropped_busy_cycles got=%0d exp=65", busy_cnt); end
        checks++; if (first_low !== 66) begin failures++; $display("FAIL dropped_busy_low got=%0d exp=66", first_low); end
        checks++; if (gen_count !== 16'(gen_m)) begin failures++; $display("FAIL dropped_gen got=%0d exp=%0d", gen_count, gen_m); end
        read_board(got);
        checks++; if (got !== model_vec()) begin failures++; $display("FAIL dropped_board got=%h exp=%h", got, model_vec()); end
    endtask

    task automatic test_abort();
        logic [W*H-1:0] got;
        int cyc;
        bit flip;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                do_write(r, c, ($urandom_range(0, 1) == 1));
        flip = ~model[5][5];
        mode = 1'b1;
        change_state = 1'b1;
        @(posedge clk); #1;
        change_state = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
        mode = 1'b0;
        write_en = 1'b1; wAddrR = 8'd5; wAddrC = 8'd5; write_data = flip;
        @(posedge clk); #1;
        write_en = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy_after got=%b exp=0", busy); end
        checks++; if (gen_count !== 16'(gen_m)) begin failures++; $display("FAIL abort_gen got=%0d exp=%0d", gen_count, gen_m); end
        checks++; if (alive_count !== 16'(alive_m)) begin failures++; $display("FAIL abort_alive got=%0d exp=%0d", alive_count, alive_m); end
        read_board(got);
        checks++; if (got !== model_vec()) begin failures++; $display("FAIL abort_board got=%h exp=%h", got, model_vec()); end
        run_gen(cyc);
        step_model();
        read_board(got);
        checks++; if (got !== model_vec()) begin failures++; $display("FAIL abort_rerun_board got=%h exp=%h", got, model_vec()); end
        checks++; if (cyc !== 65) begin failures++; $display("FAIL abort_rerun_latency got=%0d exp=65", cyc); end
    endtask

    task automatic test_reset_mid();
        logic [W*H-1:0] got;
        int cyc;
        do_write(0, 0, 1'b1);
        rAddrR = 8'd0; rAddrC = 8'd0;
        mode = 1'b1;
        change_state = 1'b1;
        @(posedge clk); #1;
        change_state = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        checks++; if (rData !== 1'b1) begin failures++; $display("FAIL midrst_rdata_before got=%b exp=1", rData); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (rData !== 1'b0) begin failures++; $display("FAIL midrst_rdata got=%b exp=0", rData); end
        checks++; if (gen_count !== 16'd0) begin failures++; $display("FAIL midrst_gen got=%0d exp=0", gen_count); end
        checks++; if (alive_count !== 16'd0) begin failures++; $display("FAIL midrst_alive got=%0d exp=0", alive_count); end
        @(posedge clk); #1;
        rst = 1'b1;
        mode = 1'b0;
        model_clear();
        @(posedge clk); #1;
        read_board(got);
        checks++; if (got !== model_vec()) begin failures++; $display("FAIL midrst_board got=%h exp=%h", got, model_vec()); end
        do_write(2, 5, 1'b1);
        do_write(3, 5, 1'b1);
        do_write(4, 5, 1'b1);
        run_gen(cyc);
        step_model();
        checks++; if (cyc !== 65) begin failures++; $display("FAIL midrst_fresh_latency got=%0d exp=65", cyc); end
        read_board(got);
        checks++; if (got !== model_vec()) begin failures++; $display("FAIL midrst_fresh_board got=%h exp=%h", got, model_vec()); end
        checks++; if (gen_count !== 16'd1) begin failures++; $display("FAIL midrst_fresh_gen got=%0d exp=1", gen_count); end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_wrap();
        test_random();
        test_ignored_writes();
        test_dropped_edge();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_cell_board.md
LIFE_CELL_BOARD -- requirements
Module: life_cell_board

Interface
REQ-001 Parameter MAP_WIDTH, default 8, board columns (1..128).
REQ-002 Parameter MAP_HEIGHT, default 8, board rows (1..128).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mode  input  1  1 = evolve, 0 = edit.
REQ-006 change_state  input  1  iteration pacing level; each rising edge requests one generation.
REQ-007 write_en  input  1  cell write strobe, sampled every clk.
REQ-008 write_data  input  1  value written to the addressed cell.
REQ-009 wAddrR, wAddrC  input  8 each  write row/column.
REQ-010 rAddrR, rAddrC  input  8 each  display read row/column.
REQ-011 rData  output  1  registered cell value at the read address.
REQ-012 busy  output  1  high while a generation is being computed.
REQ-013 gen_count  output  16  generations committed since reset.
REQ-014 alive_count  output  16  live-cell population of the last committed generation.

Function
REQ-015 Storage SHALL be two banks of MAP_WIDTH*MAP_HEIGHT bits: cur (visible board) and nxt (scratch).
REQ-016 FSM states SHALL be IDLE, COMPUTE and COMMIT; busy = (state != IDLE).
REQ-017 change_state SHALL be registered once (cs_q); edge = change_state & ~cs_q.
REQ-018 IDLE -> COMPUTE when edge & mode; scan indices r=0, c=0; population accumulator cleared.
REQ-019 COMPUTE SHALL evaluate one cell per clk, row-major: c increments; at c=MAP_WIDTH-1, c wraps to 0 and r increments.
REQ-020 Neighbour count SHALL read only cur, over 8 neighbours with toroidal wrap (row -1 -> MAP_HEIGHT-1, column MAP_WIDTH -> 0, etc.); count width 4 bits.
REQ-021 nxt[r][c] SHALL be (n==3) | (cur[r][c] & n==2); accumulator increments when that result is 1.
REQ-022 After cell (MAP_HEIGHT-1, MAP_WIDTH-1) -> COMMIT; COMMIT SHALL copy nxt to cur in one clk, gen_count += 1 (wraps 0xFFFF -> 0), latch alive_count, then -> IDLE.
REQ-023 Latency: edge sampled in IDLE to cur updated = MAP_WIDTH*MAP_HEIGHT+1 clk; busy high for exactly that many cycles.
REQ-024 Edges arriving while busy SHALL be dropped, not queued.
REQ-025 mode falling to 0 during COMPUTE SHALL abort: -> IDLE next clk, cur unchanged, gen_count and alive_count unchanged.
REQ-026 Writes SHALL be accepted only when mode=0 and state=IDLE: cur[wAddrR][wAddrC] <= write_data next clk.
REQ-027 Writes with wAddrR>=MAP_HEIGHT or wAddrC>=MAP_WIDTH SHALL be ignored; writes with mode=1 or busy=1 SHALL be ignored.
REQ-028 Edits SHALL NOT modify gen_count or alive_count.
REQ-029 rData SHALL be cur at (rAddrR, rAddrC) registered, 1-clk latency; out-of-range address returns 0.
REQ-030 rData SHALL reflect cur only; nxt is never visible before COMMIT.

Reset
REQ-031 rst low SHALL force within the same cycle: state IDLE, cur and nxt all 0, cs_q 0, r=c=0, rData 0, busy 0, gen_count 0, alive_count 0.
REQ-032 Reset asserted mid-COMPUTE SHALL discard the scan; first edge after release starts a fresh generation.

Verification
REQ-033 Blinker: edit-write (3,2),(3,3),(3,4) =1, mode=1, one change_state edge -> after 65 clk, cur holds (2,3),(3,3),(4,3); gen_count=1, alive_count=3; second edge restores the horizontal row, gen_count=2.
REQ-034 Wrap: cells (0,7),(7,7),(1,7) set -> after one generation, (0,6),(0,7),(0,0) live (toroidal neighbours), alive_count=3.
REQ-035 Ignored writes: mode=1, write_en=1 at (0,0) data 1 -> cur[0][0] stays 0; write at wAddrC=8 with mode=0 -> no cell changes.
REQ-036 Dropped edge: second change_state edge 10 clk after the first -> gen_count=1 after 130 clk, busy low 65 clk after the first edge.
REQ-037 Abort: mode 1->0 at cycle 20 of COMPUTE -> busy low next clk, cur, gen_count, alive_count unchanged.
REQ-038 Reset mid-COMPUTE: rst low at cycle 30 -> all outputs 0 immediately, board all 0, gen_count 0.
